fft_overlap_ctrl: RTL and testbench
===================================

# fft_overlap_ctrl

Parametrised write-request controller for the FFT input FIFO. It arms when the FIFO fill level reaches a run-time threshold, then issues a burst of write requests. The burst ends on FIFO full (legacy mode) or after a programmed word count (counted mode). It adds hysteresis re-arm, enable gating, frame-done/truncation pulses and a frame counter. It sits between the sample FIFO status outputs and the overlap write port feeding the FFT core.

## Interface
- USEDW_W, 5, width of FIFO used-words count and threshold
- CNT_W, 8, width of counted-mode burst length
- FCNT_W, 16, width of completed-frame counter
- clk  in  1  system clock, all logic on rising edge
- iRst_n  in  1  synchronous, active-low reset
- iEn  in  1  controller enable; low forces IDLE
- iMode  in  1  0 = fill-until-full, 1 = counted burst
- iThresh  in  USEDW_W  arm threshold on used-words
- iCount  in  CNT_W  counted-mode burst length, latched at burst start
- iUsedW  in  USEDW_W  FIFO used-words
- iFull  in  1  FIFO full flag
- oWrreq  out  1  FIFO write request
- oBusy  out  1  high while in FILL
- oFrameDone  out  1  one-cycle pulse on every FILL exit
- oTrunc  out  1  one-cycle pulse when a counted burst is cut short by iFull
- oFrameCnt  out  FCNT_W  number of completed bursts, wraps

## Operation
- States: IDLE, ARM, FILL, REARM.
- IDLE: leaves to ARM when iEn=1.
- ARM: goes to FILL when iUsedW >= iThresh (unsigned) and iFull=0. iCount and iMode are latched on this transition.
- FILL: oWrreq=1. An accepted write is a cycle with oWrreq=1 and iFull=0; the accepted-write counter increments on each one.
  - Mode 0: exit when iFull=1 is sampled.
  - Mode 1: exit on the cycle the accepted count reaches the latched count. A latched count of 0 means 2^CNT_W writes.
  - Mode 1 with iFull=1 before the count completes: exit, and pulse oTrunc together with oFrameDone.
  - On every exit: pulse oFrameDone, increment oFrameCnt, go to REARM.
- REARM: returns to ARM only when iUsedW < iThresh and iFull=0. This hysteresis prevents an immediate re-trigger on the same fill level.
- iEn=0 in any state: next state IDLE.
  - If that happens in FILL, oFrameDone is not pulsed and oFrameCnt is unchanged; the partial burst is discarded.
  - The accepted-write counter clears on entry to FILL.
- iThresh=0: ARM proceeds to FILL as soon as iFull=0. REARM can never satisfy its exit condition, so only iEn=0 releases it.
- Simultaneous events: in mode 1, if the count completes on the same cycle iFull rises, the burst counts as complete (no oTrunc). iEn=0 has priority over all other transitions.
- oFrameCnt wraps from 2^FCNT_W-1 to 0.

## Timing
- Reset (iRst_n=0 at a clk edge): state=IDLE, oWrreq=0, oBusy=0, oFrameDone=0, oTrunc=0, oFrameCnt=0, counter=0. Reset overrides iEn.
- oWrreq and oBusy are decoded directly from the state register: high exactly in the cycles where state=FILL.
- Arm latency: the arm condition is sampled at edge N, so oWrreq is high from cycle N+1.
- Exit latency: iFull=1 or count completion is sampled at edge M, so oWrreq is low from cycle M+1. Exactly one write is issued while full, and the FIFO ignores it.
- Mode 1 with no iFull: exactly latched-count consecutive oWrreq cycles.
- oFrameDone, oTrunc and the oFrameCnt update are registered. They are visible in the first cycle after FILL, i.e. the same cycle oWrreq drops.
- The minimum gap between bursts is 2 cycles (REARM and ARM each last at least one cycle).

## Structure
- Shared package fft_ovl_pkg:
  - state enum (IDLE=0, ARM=1, FILL=2, REARM=3) with safe encoding
  - mode constants MODE_FULL=0, MODE_CNT=1
- Sub-module fft_ovl_burst_cnt holds the accepted-write counter:
  - load on FILL entry, increment on accepted write
  - outputs a done flag compared against the latched count, with 0 meaning 2^CNT_W
- The top level holds the FSM, the output pulses and oFrameCnt.

## Test plan
- Mode 0, iThresh=14: ramp iUsedW 0..14 → oWrreq rises the cycle after usedw=14. Raise iFull 5 cycles later → oWrreq drops next cycle, oFrameDone pulse, oFrameCnt=1.
- Mode 1, iCount=4, iFull never high → exactly 4 oWrreq cycles, oFrameDone on the 5th, oTrunc=0. Hold iUsedW ≥ thresh → no re-arm until iUsedW < thresh.
- Mode 1, iCount=8, iFull high after 3 accepted writes → exit, oFrameDone and oTrunc pulse together, oFrameCnt increments.
- iEn dropped mid-FILL → IDLE next cycle, oWrreq=0, no oFrameDone, oFrameCnt unchanged. Reassert iEn → ARM.
- iRst_n low mid-FILL for 1 cycle → all outputs 0 next cycle, oFrameCnt=0, state IDLE.
- FCNT_W=4: run 17 counted bursts of iCount=0 (256 writes each) → oFrameCnt wraps to 1.

Source files
------------

// File: rtl/fft_ovl_pkg.sv
// Shared definitions for the FFT overlap write-request controller.
//   state_t   : controller FSM state encoding (all four codes used)
//   MODE_FULL : burst runs until the FIFO reports full
//   MODE_CNT  : burst runs for a programmed number of accepted writes
package fft_ovl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_FILL  = 2'd2,
        ST_REARM = 2'd3
    } state_t;

    localparam logic MODE_FULL = 1'b0;
    localparam logic MODE_CNT  = 1'b1;

endpackage

// File: rtl/fft_ovl_burst_cnt.sv
// Accepted-write counter for counted-mode bursts.
//   clk        : system clock
//   rst_n      : synchronous active-low reset
//   load       : clear the counter and capture load_count (burst start)
//   load_count : burst length; 0 stands for 2^CNT_W writes
//   accept     : a write was accepted by the FIFO this cycle
//   done       : this accepted write is the last one of the burst
module fft_ovl_burst_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_count,
    input  logic             accept,
    output logic             done
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] cnt_inc;

    // The increment wraps at CNT_W bits, so a target of 0 matches only
    // after 2^CNT_W accepted writes.
    assign cnt_inc = cnt + 1'b1;
    assign done    = accept && (cnt_inc == target);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            target <= '0;
        end else if (load) begin
            cnt    <= '0;
            target <= load_count;
        end else if (accept) begin
            cnt    <= cnt_inc;
        end
    end

endmodule

// File: rtl/fft_overlap_ctrl.sv
// Write-request controller for the FFT input FIFO. Arms on a fill-level
// threshold, issues a burst of write requests until full (mode 0) or a
// programmed count (mode 1), then waits for the level to fall below the
// threshold before re-arming.
//   clk        : system clock
//   iRst_n     : synchronous active-low reset
//   iEn        : enable, low forces IDLE and discards any partial burst
//   iMode      : 0 = fill until full, 1 = counted burst (latched at start)
//   iThresh    : arm / re-arm threshold on used-words
//   iCount     : counted burst length, 0 = 2^CNT_W (latched at start)
//   iUsedW     : FIFO used-words
//   iFull      : FIFO full flag
//   oWrreq     : FIFO write request (state FILL)
//   oBusy      : high while in FILL
//   oFrameDone : one-cycle pulse after every completed burst
//   oTrunc     : one-cycle pulse when a counted burst was cut by iFull
//   oFrameCnt  : completed bursts, wrapping
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | disabled, waiting for iEn
// ARM   | waiting for used-words >= threshold with FIFO not full
// FILL  | issuing write requests
// REARM | hysteresis, waiting for used-words < threshold, not full
module fft_overlap_ctrl
    import fft_ovl_pkg::*;
#(
    parameter int USEDW_W = 5,
    parameter int CNT_W   = 8,
    parameter int FCNT_W  = 16
) (
    input  logic               clk,
    input  logic               iRst_n,
    input  logic               iEn,
    input  logic               iMode,
    input  logic [USEDW_W-1:0] iThresh,
    input  logic [CNT_W-1:0]   iCount,
    input  logic [USEDW_W-1:0] iUsedW,
    input  logic               iFull,
    output logic               oWrreq,
    output logic               oBusy,
    output logic               oFrameDone,
    output logic               oTrunc,
    output logic [FCNT_W-1:0]  oFrameCnt
);

    state_t state;
    state_t state_next;
    logic   mode_q;
    logic   load;
    logic   accept;
    logic   cnt_done;
    logic   exit_done;
    logic   exit_trunc;

    assign oWrreq = (state == ST_FILL);
    assign oBusy  = (state == ST_FILL);
    assign accept = (state == ST_FILL) && !iFull;

    fft_ovl_burst_cnt #(
        .CNT_W(CNT_W)
    ) u_burst_cnt (
        .clk       (clk),
        .rst_n     (iRst_n),
        .load      (load),
        .load_count(iCount),
        .accept    (accept),
        .done      (cnt_done)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        exit_done  = 1'b0;
        exit_trunc = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iEn) state_next = ST_ARM;
            end
            ST_ARM: begin
                if ((iUsedW >= iThresh) && !iFull) begin
                    state_next = ST_FILL;
                    load       = 1'b1;
                end
            end
            ST_FILL: begin
                if (mode_q == MODE_FULL) begin
                    if (iFull) begin
                        exit_done  = 1'b1;
                        state_next = ST_REARM;
                    end
                end else if (cnt_done) begin
                    // Completion wins over a concurrent full flag.
                    exit_done  = 1'b1;
                    state_next = ST_REARM;
                end else if (iFull) begin
                    exit_done  = 1'b1;
                    exit_trunc = 1'b1;
                    state_next = ST_REARM;
                end
            end
            ST_REARM: begin
                if ((iUsedW < iThresh) && !iFull) state_next = ST_ARM;
            end
            default: state_next = ST_IDLE;
        endcase
        // Disable overrides everything; a burst cut this way is not reported.
        if (!iEn) begin
            state_next = ST_IDLE;
            load       = 1'b0;
            exit_done  = 1'b0;
            exit_trunc = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!iRst_n) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_FULL;
            oFrameDone <= 1'b0;
            oTrunc     <= 1'b0;
            oFrameCnt  <= '0;
        end else begin
            state      <= state_next;
            oFrameDone <= exit_done;
            oTrunc     <= exit_trunc;
            if (load) mode_q <= (iMode == MODE_CNT) ? MODE_CNT : MODE_FULL;
            if (exit_done) oFrameCnt <= oFrameCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_overlap_ctrl.sv
// Directed bench for fft_overlap_ctrl: a per-cycle vector table plus a
// hand-written frame-counter wrap sequence with 2^CNT_W-write bursts.
module tb_fft_overlap_ctrl;

    localparam int USEDW_W = 5;
    localparam int CNT_W   = 8;
    localparam int FCNT_W  = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               mode;
    logic [USEDW_W-1:0] thresh;
    logic [CNT_W-1:0]   count;
    logic [USEDW_W-1:0] usedw;
    logic               full;
    logic               wrreq;
    logic               busy;
    logic               frame_done;
    logic               trunc;
    logic [FCNT_W-1:0]  frame_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fft_overlap_ctrl #(
        .USEDW_W(USEDW_W),
        .CNT_W  (CNT_W),
        .FCNT_W (FCNT_W)
    ) dut (
        .clk       (clk),
        .iRst_n    (rst_n),
        .iEn       (en),
        .iMode     (mode),
        .iThresh   (thresh),
        .iCount    (count),
        .iUsedW    (usedw),
        .iFull     (full),
        .oWrreq    (wrreq),
        .oBusy     (busy),
        .oFrameDone(frame_done),
        .oTrunc    (trunc),
        .oFrameCnt (frame_cnt)
    );

    typedef struct {
        logic               rst_n;
        logic               en;
        logic               mode;
        logic [USEDW_W-1:0] thresh;
        logic [CNT_W-1:0]   count;
        logic [USEDW_W-1:0] usedw;
        logic               full;
        logic               exp_wr;
        logic               exp_done;
        logic               exp_trunc;
        logic [FCNT_W-1:0]  exp_fcnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic e, input logic m,
                                input int th, input int c, input int u,
                                input logic f, input logic w, input logic d,
                                input logic t, input int fc);
        vec_t v;
        v.rst_n     = r;
        v.en        = e;
        v.mode      = m;
        v.thresh    = USEDW_W'(th);
        v.count     = CNT_W'(c);
        v.usedw     = USEDW_W'(u);
        v.full      = f;
        v.exp_wr    = w;
        v.exp_done  = d;
        v.exp_trunc = t;
        v.exp_fcnt  = FCNT_W'(fc);
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic m,
                         input logic [USEDW_W-1:0] th, input logic [CNT_W-1:0] c,
                         input logic [USEDW_W-1:0] u, input logic f);
        @(negedge clk);
        rst_n  = r;
        en     = e;
        mode   = m;
        thresh = th;
        count  = c;
        usedw  = u;
        full   = f;
    endtask

    initial begin
        int nwr;
        bit seen;
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; thresh = '0;
        count = '0; usedw = '0; full = 1'b0;

        // --- mode 0, threshold 14, ramp then full ---
        add(0,1,0,14,0,0,0, 0,0,0,0);
        add(1,1,0,14,0,0,0, 0,0,0,0);
        for (int u = 1; u <= 13; u++) add(1,1,0,14,0,u,0, 0,0,0,0);
        add(1,1,0,14,0,14,0, 1,0,0,0);
        for (int k = 0; k < 4; k++) add(1,1,0,14,0,14,0, 1,0,0,0);
        add(1,1,0,14,0,14,1, 0,1,0,1);
        add(1,1,0,14,0,14,1, 0,0,0,1);
        add(1,1,0,14,0,14,0, 0,0,0,1);
        add(1,1,0,14,0,3,0,  0,0,0,1);
        // --- mode 1, count 4, no full; count/mode changes after start ignored ---
        add(1,1,1,14,4,20,0, 1,0,0,1);
        for (int k = 0; k < 3; k++) add(1,1,1,14,9,20,0, 1,0,0,1);
        add(1,1,1,14,9,20,0, 0,1,0,2);
        for (int k = 0; k < 3; k++) add(1,1,1,14,9,20,0, 0,0,0,2);
        add(1,1,1,14,9,5,0,  0,0,0,2);
        // --- mode 1, count 8, full after 3 accepted writes -> truncation ---
        add(1,1,1,14,8,20,0, 1,0,0,2);
        for (int k = 0; k < 3; k++) add(1,1,0,14,0,20,0, 1,0,0,2);
        add(1,1,0,14,0,20,1, 0,1,1,3);
        add(1,1,0,14,0,20,1, 0,0,0,3);
        add(1,1,0,14,0,0,0,  0,0,0,3);
        // --- enable dropped mid-FILL ---
        add(1,1,0,14,0,20,0, 1,0,0,3);
        add(1,1,0,14,0,20,0, 1,0,0,3);
        add(1,0,0,14,0,20,0, 0,0,0,3);
        add(1,0,0,14,0,20,0, 0,0,0,3);
        add(1,1,0,14,0,20,0, 0,0,0,3);
        add(1,1,0,14,0,20,0, 1,0,0,3);
        add(1,1,0,14,0,20,1, 0,1,0,4);
        add(1,1,0,14,0,0,0,  0,0,0,4);
        // --- reset mid-FILL ---
        add(1,1,0,14,0,20,0, 1,0,0,4);
        add(0,1,0,14,0,20,0, 0,0,0,0);
        add(1,1,0,14,0,20,0, 0,0,0,0);
        add(1,1,0,14,0,20,0, 1,0,0,0);
        // --- threshold 0: REARM stuck until disable ---
        add(1,1,0,0,0,0,1,   0,1,0,1);
        for (int k = 0; k < 3; k++) add(1,1,0,0,0,0,0, 0,0,0,1);
        add(1,0,0,0,0,0,0,   0,0,0,1);
        add(1,1,0,0,0,0,1,   0,0,0,1);
        add(1,1,0,0,0,0,1,   0,0,0,1);
        add(1,1,0,0,0,0,0,   1,0,0,1);
        add(1,0,0,0,0,0,0,   0,0,0,1);
        // --- mode 1, count 1 -> single write ---
        add(1,1,1,14,1,0,0,  0,0,0,1);
        add(1,1,1,14,1,20,0, 1,0,0,1);
        add(1,1,1,14,1,20,0, 0,1,0,2);
        add(1,1,1,14,1,20,1, 0,0,0,2);
        add(1,1,1,14,1,0,0,  0,0,0,2);
        // --- mode 1, full on first FILL cycle -> truncation with no writes ---
        add(1,1,1,14,5,20,0, 1,0,0,2);
        add(1,1,1,14,5,20,1, 0,1,1,3);
        add(1,0,1,14,5,20,1, 0,0,0,3);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].en, vecs[i].mode, vecs[i].thresh,
                  vecs[i].count, vecs[i].usedw, vecs[i].full);
            @(posedge clk);
            #1;
            tests_run++;
            if (wrreq !== vecs[i].exp_wr || busy !== vecs[i].exp_wr ||
                frame_done !== vecs[i].exp_done || trunc !== vecs[i].exp_trunc ||
                frame_cnt !== vecs[i].exp_fcnt) begin
                tests_failed++;
                $display("FAIL vec%0d: got wr=%0b busy=%0b done=%0b trunc=%0b fcnt=%0d expected wr=%0b busy=%0b done=%0b trunc=%0b fcnt=%0d",
                         i, wrreq, busy, frame_done, trunc, frame_cnt,
                         vecs[i].exp_wr, vecs[i].exp_wr, vecs[i].exp_done,
                         vecs[i].exp_trunc, vecs[i].exp_fcnt);
            end
        end

        // --- 17 counted bursts of 2^CNT_W writes: frame counter wraps to 1 ---
        drive(0, 1, 1, 14, 0, 0, 0);
        @(posedge clk);
        #1;
        check("wrap_reset_fcnt", int'(frame_cnt), 0);
        for (int b = 0; b < 17; b++) begin
            drive(1, 1, 1, 14, 0, 20, 0);
            nwr  = 0;
            seen = 1'b0;
            for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
                @(posedge clk);
                #1;
                if (wrreq) nwr++;
                if (frame_done) seen = 1'b1;
            end
            check($sformatf("wrap_done_seen_b%0d", b), int'(seen), 1);
            check($sformatf("wrap_writes_b%0d", b), nwr, 1 << CNT_W);
            check($sformatf("wrap_fcnt_b%0d", b), int'(frame_cnt), (b + 1) % (1 << FCNT_W));
            drive(1, 1, 1, 14, 0, 0, 0);
            @(posedge clk);
            @(posedge clk);
        end
        check("wrap_final_fcnt", int'(frame_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
